// File: rtl/router_pkg.sv
// Shared constants for the destination router: FSM encoding and word layout.
package router_pkg;

  localparam int RT_WORD_SIZE = 10;
  localparam int RT_DATA_SIZE = 8;
  localparam int RT_DEST_W    = RT_WORD_SIZE - RT_DATA_SIZE;
  localparam int RT_DEST_HI   = RT_WORD_SIZE - 1;
  localparam int RT_DEST_LO   = RT_DATA_SIZE;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_ROUTE = 2'd2;

endpackage

// File: rtl/route_counter.sv
// Wrapping per-destination routed-word counter.
module route_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  // Wraps modulo 2**CNT_W by plain overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else if (inc_i) count_q <= count_q + CNT_W'(1);
  end

  assign count_o = count_q;

endmodule

// File: rtl/dest_router.sv
// Pops words from the input FIFO and steers each payload to one of NUM_DEST
// destination FIFOs, honouring only the addressed destination's almost_full.
module dest_router
  import router_pkg::*;
#(
  parameter int WORD_SIZE = RT_WORD_SIZE,
  parameter int DATA_SIZE = RT_DATA_SIZE,
  parameter int NUM_DEST  = 4,
  parameter int CNT_W     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      fifo_empty,
  input  logic [WORD_SIZE-1:0]      fifo_data_out,
  output logic                      fifo_rd,
  input  logic [NUM_DEST-1:0]       dest_almost_full,
  output logic [NUM_DEST-1:0]       push_out,
  output logic [DATA_SIZE-1:0]      data_out,
  output logic [NUM_DEST*CNT_W-1:0] words_routed,
  output logic                      idle
);

  localparam int DW = WORD_SIZE - DATA_SIZE;

  logic [1:0]           state_q, state_d;
  logic [WORD_SIZE-1:0] hold_q, hold_d;
  logic [NUM_DEST-1:0]  push_q, push_d;
  logic [DATA_SIZE-1:0] data_q, data_d;
  logic [DW-1:0]        dest;
  logic                 go;
  logic                 route_fire;
  logic                 pop_ok;

  assign dest       = hold_q[WORD_SIZE-1:DATA_SIZE];
  assign go         = ~dest_almost_full[dest];
  assign route_fire = (state_q == ST_ROUTE) && go;
  // Gating with reset keeps the pop strobe quiet while the FSM is held.
  assign pop_ok     = enable & ~fifo_empty & ~reset;
  assign fifo_rd    = pop_ok & ((state_q == ST_IDLE) | route_fire);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    push_d  = '0;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (fifo_rd) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        hold_d  = fifo_data_out;
        state_d = ST_ROUTE;
      end
      ST_ROUTE: begin
        if (go) begin
          push_d  = NUM_DEST'(1) << dest;
          data_d  = hold_q[DATA_SIZE-1:0];
          state_d = fifo_rd ? ST_FETCH : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      push_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      push_q  <= push_d;
      data_q  <= data_d;
    end
  end

  for (genvar i = 0; i < NUM_DEST; i++) begin : g_cnt
    route_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .inc_i   (route_fire && (dest == DW'(i))),
      .count_o (words_routed[i*CNT_W +: CNT_W])
    );
  end

  assign push_out = push_q;
  assign data_out = data_q;
  assign idle     = (state_q == ST_IDLE) & fifo_empty;

endmodule
